a_b_link_ctrl: RTL and testbench
================================

A_B_LINK_CTRL -- requirements
Module: a_b_link_ctrl

Interface
REQ-001 Parameter DATA_TO_A_BITWIDTH, default `DATA_TO_A_BITWIDTH (8), width of request data toward A.
REQ-002 Parameter DATA_FROM_A_BITWIDTH, default `DATA_FROM_A_BITWIDTH (8), width of response data from A.
REQ-003 Parameter MAX_OUTSTANDING, default 4, maximum number of issued requests awaiting a response; a power of two, at least 2.
REQ-004 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Ports req0_valid and req1_valid, input, 1 each, requester N offers a word.
REQ-007 Ports req0_data and req1_data, input, DATA_TO_A_BITWIDTH each, requester N payload.
REQ-008 Ports req0_ready and req1_ready, output, 1 each, requester N word accepted this cycle.
REQ-009 Port data_to_a, output, DATA_TO_A_BITWIDTH, registered request word toward A.
REQ-010 Port to_a_valid, output, 1, data_to_a holds a pending request.
REQ-011 Port to_a_ready, input, 1, A takes data_to_a this cycle.
REQ-012 Port data_from_a, input, DATA_FROM_A_BITWIDTH, response word from A.
REQ-013 Port from_a_valid, input, 1, response present; A has no backpressure.
REQ-014 Ports rsp0_valid and rsp1_valid, output, 1 each, one-cycle pulse marking a response for requester N.
REQ-015 Port rsp_data, output, DATA_FROM_A_BITWIDTH, registered response word.
REQ-016 Port outstanding, output, $clog2(MAX_OUTSTANDING)+1, current in-flight count.
REQ-017 Port err_unexp, output, 1, sticky flag for a response arriving with nothing in flight.

Function
REQ-018 FSM states SHALL be IDLE, SEND and FULL.
REQ-019 In IDLE with outstanding==MAX_OUTSTANDING, the FSM SHALL move to FULL and accept nothing.
REQ-020 In IDLE with outstanding<MAX_OUTSTANDING and at least one reqN_valid, the block SHALL grant one requester combinationally:
- reqN_ready=1 for the winner only.
- The winner's data is latched into data_to_a.
- The FSM moves to SEND.
REQ-021 Arbitration SHALL be round-robin: on a tie, the requester not most recently granted wins; after reset, req0 wins the first tie.
REQ-022 In SEND, to_a_valid SHALL be 1 and data_to_a SHALL stay stable until to_a_ready=1.
- On that edge, the granted ID is pushed to the tag FIFO and the FSM moves to IDLE.
- No requester is accepted while in SEND.
REQ-023 In FULL, the FSM SHALL return to IDLE on the first edge where outstanding<MAX_OUTSTANDING.
REQ-024 On from_a_valid=1 with outstanding>0 (value before this edge), the block SHALL:
- pop the oldest tag;
- register data_from_a into rsp_data;
- pulse the matching rspN_valid in the next cycle (latency 1).
REQ-025 On from_a_valid=1 with outstanding==0, the block SHALL drop the response, set err_unexp, and assert no rsp valid.
REQ-026 A push and a pop on the same edge SHALL leave outstanding unchanged; the FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-027 rsp_data SHALL hold its last value when no response is pulsed.
REQ-028 Responses SHALL be returned strictly in issue order.

Reset
REQ-029 While rst_n=0, the block SHALL hold:
- FSM in IDLE;
- to_a_valid=0, data_to_a=0;
- rsp0_valid=0, rsp1_valid=0, rsp_data=0;
- outstanding=0, err_unexp=0;
- FIFO pointers=0;
- round-robin pointer favouring req0.
REQ-030 Reset asserted mid-SEND or with requests in flight SHALL discard them; responses arriving after reset release SHALL count as unexpected.
REQ-031 reqN_ready SHALL be 0 while rst_n=0.

Structure
REQ-032 The FSM state encoding and the requester-ID width SHALL live in shared package a_b_link_pkg.
REQ-033 The bitwidth defaults SHALL come from config.vh.
REQ-034 The tag FIFO SHALL be a sub-module, a_b_tag_fifo: depth MAX_OUTSTANDING, width 1, with count, full and empty outputs.

Verification
REQ-035 Single request: req0_valid=1, req0_data=0x5A, to_a_ready=1 -> req0_ready pulses once; next cycle data_to_a=0x5A, to_a_valid=1; outstanding=1.
REQ-036 Tie: both valid from reset, to_a_ready=1 -> grants alternate req0, req1, req0, req1.
REQ-037 Backpressure: to_a_ready=0 for 5 cycles in SEND -> data_to_a stable; both reqN_ready=0; transfer completes on the cycle ready rises.
REQ-038 Full: 4 requests issued, no responses -> FSM in FULL with outstanding=4; one response (data_from_a=0x33) -> rsp pulse with rsp_data=0x33, then a new grant follows.
REQ-039 Ordering: issue req1 then req0; return responses 0x11 then 0x22 -> rsp1_valid with 0x11, then rsp0_valid with 0x22; a push and a pop on the same edge keeps outstanding constant.
REQ-040 Unexpected response and reset: from_a_valid with outstanding=0 -> err_unexp=1 and no rsp pulse; rst_n pulsed low mid-SEND -> all outputs at reset values.

Source files
------------

// File: rtl/a_b_link_pkg.sv
// Shared types for the A/B link controller: FSM encoding and requester IDs.
package a_b_link_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StFull = 2'd2
    } link_state_e;

    localparam int unsigned ReqIdWidth = 1;
    typedef logic [ReqIdWidth-1:0] req_id_t;

    // Round-robin pick between two requesters; favour wins only on a tie.
    function automatic req_id_t rr_pick(input logic v0, input logic v1, input req_id_t favour);
        if (v0 && v1) begin
            return favour;
        end else if (v1) begin
            return req_id_t'(1);
        end
        return req_id_t'(0);
    endfunction

endpackage

// File: rtl/a_b_link_ctrl_if.sv
// Requester, A-side and status signals of the A/B link controller.
`include "config.vh"

interface a_b_link_ctrl_if #(
    parameter int unsigned DATA_TO_A_BITWIDTH   = `DATA_TO_A_BITWIDTH,
    parameter int unsigned DATA_FROM_A_BITWIDTH = `DATA_FROM_A_BITWIDTH,
    parameter int unsigned MAX_OUTSTANDING      = 4
);
    localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING) + 1;

    logic                            req0_valid;
    logic                            req1_valid;
    logic [DATA_TO_A_BITWIDTH-1:0]   req0_data;
    logic [DATA_TO_A_BITWIDTH-1:0]   req1_data;
    logic                            req0_ready;
    logic                            req1_ready;
    logic [DATA_TO_A_BITWIDTH-1:0]   data_to_a;
    logic                            to_a_valid;
    logic                            to_a_ready;
    logic [DATA_FROM_A_BITWIDTH-1:0] data_from_a;
    logic                            from_a_valid;
    logic                            rsp0_valid;
    logic                            rsp1_valid;
    logic [DATA_FROM_A_BITWIDTH-1:0] rsp_data;
    logic [CntWidth-1:0]             outstanding;
    logic                            err_unexp;

    // Controller view.
    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data, to_a_ready, data_from_a,
               from_a_valid,
        output req0_ready, req1_ready, data_to_a, to_a_valid, rsp0_valid, rsp1_valid,
               rsp_data, outstanding, err_unexp
    );

    // Environment view (requesters plus A).
    modport master (
        output req0_valid, req1_valid, req0_data, req1_data, to_a_ready, data_from_a,
               from_a_valid,
        input  req0_ready, req1_ready, data_to_a, to_a_valid, rsp0_valid, rsp1_valid,
               rsp_data, outstanding, err_unexp
    );

endinterface

// File: rtl/a_b_tag_fifo.sv
// Small tag FIFO holding the requester ID of each request in flight to A.
module a_b_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PtrWidth = $clog2(DEPTH);
    localparam logic [PtrWidth:0] DepthCnt = (PtrWidth + 1)'(DEPTH);

    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrWidth:0]   count_q;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic                do_push, do_pop;

    // Flags and guarded push/pop strobes.
    always_comb begin
        full    = (count_q == DepthCnt);
        empty   = (count_q == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem_q[rd_ptr_q];
        count   = count_q;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/config.vh
// Build-wide default bitwidths for the A/B link.
`ifndef A_B_LINK_CONFIG_VH
`define A_B_LINK_CONFIG_VH

`define DATA_TO_A_BITWIDTH   8
`define DATA_FROM_A_BITWIDTH 8

`endif

// File: rtl/a_b_link_ctrl.sv
// Arbitrates two requesters onto link A and routes in-order responses back.
`include "config.vh"

module a_b_link_ctrl
    import a_b_link_pkg::*;
#(
    parameter int unsigned DATA_TO_A_BITWIDTH   = `DATA_TO_A_BITWIDTH,
    parameter int unsigned DATA_FROM_A_BITWIDTH = `DATA_FROM_A_BITWIDTH,
    parameter int unsigned MAX_OUTSTANDING      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    a_b_link_ctrl_if.slave  bus
);
    localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING) + 1;

    link_state_e                     state_q, state_d;
    req_id_t                         favour_q;
    req_id_t                         word_id_q;
    req_id_t                         winner;
    req_id_t                         tag_head;
    logic [DATA_TO_A_BITWIDTH-1:0]   data_to_a_q;
    logic [DATA_FROM_A_BITWIDTH-1:0] rsp_data_q;
    logic                            rsp0_valid_q, rsp1_valid_q;
    logic                            err_q;
    logic                            any_req, grant, push, pop;
    logic [CntWidth-1:0]             tag_count;
    logic                            tag_full, tag_empty;

    a_b_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ReqIdWidth)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (word_id_q),
        .pop   (pop),
        .dout  (tag_head),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: grant from idle, hold in send until A takes the word.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (tag_full) begin
                    state_d = StFull;
                end else if (any_req) begin
                    state_d = StSend;
                end
            end
            StSend: if (bus.to_a_ready) state_d = StIdle;
            StFull: if (!tag_full) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: combinational grant and the A-side valid.
    always_comb begin
        any_req         = bus.req0_valid || bus.req1_valid;
        winner          = rr_pick(bus.req0_valid, bus.req1_valid, favour_q);
        // Gated by rst_n so no requester sees ready while reset is held.
        grant           = rst_n && (state_q == StIdle) && !tag_full && any_req;
        bus.req0_ready  = grant && (winner == req_id_t'(0));
        bus.req1_ready  = grant && (winner == req_id_t'(1));
        bus.to_a_valid  = (state_q == StSend);
        push            = (state_q == StSend) && bus.to_a_ready;
        pop             = bus.from_a_valid && !tag_empty;
    end

    // Request datapath: latch the winner's word and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_to_a_q <= '0;
            word_id_q   <= '0;
            favour_q    <= '0;
        end else if (grant) begin
            data_to_a_q <= (winner == req_id_t'(1)) ? bus.req1_data : bus.req0_data;
            word_id_q   <= winner;
            favour_q    <= ~winner;
        end
    end

    // Response datapath: route each response to the oldest tag, flag strays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q   <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rsp0_valid_q <= pop && (tag_head == req_id_t'(0));
            rsp1_valid_q <= pop && (tag_head == req_id_t'(1));
            if (pop) begin
                rsp_data_q <= bus.data_from_a;
            end
            if (bus.from_a_valid && tag_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // Drive registered results onto the interface.
    always_comb begin
        bus.data_to_a   = data_to_a_q;
        bus.rsp_data    = rsp_data_q;
        bus.rsp0_valid  = rsp0_valid_q;
        bus.rsp1_valid  = rsp1_valid_q;
        bus.outstanding = tag_count;
        bus.err_unexp   = err_q;
    end

endmodule

// File: tb/tb_a_b_link_ctrl.sv
// Randomized self-checking bench for a_b_link_ctrl against a transaction-level model.
module tb_a_b_link_ctrl;
    localparam int unsigned DW_TO   = 8;
    localparam int unsigned DW_FROM = 8;
    localparam int unsigned MAX_OUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    a_b_link_ctrl_if #(
        .DATA_TO_A_BITWIDTH   (DW_TO),
        .DATA_FROM_A_BITWIDTH (DW_FROM),
        .MAX_OUTSTANDING      (MAX_OUT)
    ) bus ();

    a_b_link_ctrl #(
        .DATA_TO_A_BITWIDTH   (DW_TO),
        .DATA_FROM_A_BITWIDTH (DW_FROM),
        .MAX_OUTSTANDING      (MAX_OUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: one word may be held toward A, a queue of requester IDs awaits responses,
    // and after the in-flight limit is hit the link pauses until a slot has been free
    // for one edge.
    bit              m_sending;
    bit              m_blocked;
    logic [DW_TO-1:0] m_word;
    int              m_word_id;
    int              m_favour;
    int              inflight[$];
    bit              m_rsp0, m_rsp1;
    logic [DW_FROM-1:0] m_rsp_data;
    bit              m_err;

    function automatic void model_reset();
        m_sending  = 1'b0;
        m_blocked  = 1'b0;
        m_word     = '0;
        m_word_id  = 0;
        m_favour   = 0;
        inflight.delete();
        m_rsp0     = 1'b0;
        m_rsp1     = 1'b0;
        m_rsp_data = '0;
        m_err      = 1'b0;
    endfunction

    function automatic int pick_winner();
        if (bus.req0_valid && bus.req1_valid) return m_favour;
        return bus.req1_valid ? 1 : 0;
    endfunction

    task automatic check_outputs();
        bit can_grant;
        int win;
        can_grant = rst_n && !m_sending && !m_blocked && (inflight.size() < int'(MAX_OUT))
                    && (bus.req0_valid || bus.req1_valid);
        win = pick_winner();
        check_eq("req0_ready", 32'(bus.req0_ready), 32'(can_grant && win == 0));
        check_eq("req1_ready", 32'(bus.req1_ready), 32'(can_grant && win == 1));
        check_eq("to_a_valid", 32'(bus.to_a_valid), 32'(m_sending));
        check_eq("data_to_a", 32'(bus.data_to_a), 32'(m_word));
        check_eq("rsp0_valid", 32'(bus.rsp0_valid), 32'(m_rsp0));
        check_eq("rsp1_valid", 32'(bus.rsp1_valid), 32'(m_rsp1));
        check_eq("rsp_data", 32'(bus.rsp_data), 32'(m_rsp_data));
        check_eq("outstanding", 32'(bus.outstanding), 32'(inflight.size()));
        check_eq("err_unexp", 32'(bus.err_unexp), 32'(m_err));
    endtask

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic model_step();
        int sz;
        int id;
        int win;
        sz = inflight.size();
        if (bus.from_a_valid && sz > 0) begin
            id         = inflight.pop_front();
            m_rsp0     = (id == 0);
            m_rsp1     = (id == 1);
            m_rsp_data = bus.data_from_a;
        end else begin
            m_rsp0 = 1'b0;
            m_rsp1 = 1'b0;
            if (bus.from_a_valid) m_err = 1'b1;
        end
        if (m_sending) begin
            if (bus.to_a_ready) begin
                inflight.push_back(m_word_id);
                m_sending = 1'b0;
            end
        end else if (m_blocked) begin
            if (sz < int'(MAX_OUT)) m_blocked = 1'b0;
        end else if (sz == int'(MAX_OUT)) begin
            m_blocked = 1'b1;
        end else if (bus.req0_valid || bus.req1_valid) begin
            win       = pick_winner();
            m_sending = 1'b1;
            m_word    = (win == 1) ? bus.req1_data : bus.req0_data;
            m_word_id = win;
            m_favour  = 1 - win;
        end
    endtask

    task automatic tick();
        #1;
        check_outputs();
        model_step();
    endtask

    task automatic drive_idle();
        bus.req0_valid   = 1'b0;
        bus.req1_valid   = 1'b0;
        bus.req0_data    = '0;
        bus.req1_data    = '0;
        bus.to_a_ready   = 1'b0;
        bus.from_a_valid = 1'b0;
        bus.data_from_a  = '0;
    endtask

    // Percent probabilities for request valid, A ready and response arrival.
    task automatic run_phase(input int n, input int p_req, input int p_rdy, input int p_rsp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.req0_valid   = ($urandom_range(99) < p_req);
            bus.req1_valid   = ($urandom_range(99) < p_req);
            bus.req0_data    = DW_TO'($urandom);
            bus.req1_data    = DW_TO'($urandom);
            bus.to_a_ready   = ($urandom_range(99) < p_rdy);
            bus.from_a_valid = ($urandom_range(99) < p_rsp);
            bus.data_from_a  = DW_FROM'($urandom);
            tick();
        end
    endtask

    // Reset pulse with requests still offered; ready must stay low throughout.
    task automatic reset_pulse();
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        check_outputs();
        drive_idle();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        drive_idle();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_phase(1, 0, 0, 100);      // stray response with nothing in flight
        run_phase(40, 100, 100, 0);   // continuous ties, fill to the in-flight limit
        run_phase(60, 100, 50, 60);
        run_phase(200, 60, 60, 30);
        run_phase(30, 80, 10, 0);     // heavy backpressure, likely mid-send
        reset_pulse();
        run_phase(3, 0, 0, 100);      // responses after reset are unexpected
        run_phase(300, 50, 50, 40);
        run_phase(100, 100, 100, 50);
        run_phase(20, 0, 0, 100);     // drain

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
